// File: rtl/dht11_sensor_emulator_pkg.sv
// Shared DHT11 protocol constants, FSM state codes and checksum helper,
// common to the sensor emulator and the host reader.
package dht11_pkg;

    localparam int T_RESP_US        = 80;
    localparam int T_BIT_LOW_US     = 50;
    localparam int T_BIT0_HIGH_US   = 26;
    localparam int T_BIT1_HIGH_US   = 70;
    localparam int T_END_LOW_US     = 50;

    // Host side: a high pulse longer than this is decoded as a 1.
    localparam int T_LIMIAR_HOST_US = 60;

    typedef enum logic [3:0] {
        E_IDLE        = 4'd0,
        E_MEDE_INICIO = 4'd1,
        E_ATRASO      = 4'd2,
        E_RESP_BAIXO  = 4'd3,
        E_RESP_ALTO   = 4'd4,
        E_BIT_BAIXO   = 4'd5,
        E_BIT_ALTO    = 4'd6,
        E_FIM_BAIXO   = 4'd7,
        E_HOLDOFF     = 4'd8
    } estado_e;

    function automatic logic [7:0] calc_checksum(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] c,
                                                 input logic [7:0] d,
                                                 input logic       inj);
        logic [7:0] soma;
        soma = a + b + c + d;
        return soma ^ {7'd0, inj};
    endfunction

endpackage

// File: rtl/dht11_sensor_emulator_if.sv
// Payload/control inputs and status outputs of the DHT11 sensor emulator.
interface dht11_sensor_emulator_if;

    logic [7:0] umidade_int;
    logic [7:0] umidade_dec;
    logic [7:0] temperatura_int;
    logic [7:0] temperatura_dec;
    logic       resposta_habilitada;
    logic       injeta_erro_checksum;
    logic       busy;
    logic       frame_done;

    modport master (
        output umidade_int, umidade_dec, temperatura_int, temperatura_dec,
        output resposta_habilitada, injeta_erro_checksum,
        input  busy, frame_done
    );

    modport slave (
        input  umidade_int, umidade_dec, temperatura_int, temperatura_dec,
        input  resposta_habilitada, injeta_erro_checksum,
        output busy, frame_done
    );

endinterface

// File: rtl/dht11_sensor_emulator_gerador_tick_us.sv
// Free-running microsecond tick: one-clock pulse every CLK_FREQ_HZ/1e6 clocks,
// built from a down-counter with terminal count at zero.
module gerador_tick_us #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick_o
);

    localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? TC : cnt_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor side: detects the host start pulse, answers with the presence
// sequence and sends the 40-bit humidity/temperature/checksum frame.
//
// state       | meaning
// IDLE        | bus released, waiting for host low
// MEDE_INICIO | measuring host start pulse
// ATRASO      | delay before the response
// RESP_BAIXO  | presence low, 80 us
// RESP_ALTO   | presence high, 80 us
// BIT_BAIXO   | bit low slot, 50 us
// BIT_ALTO    | bit high slot, 26 us (0) or 70 us (1)
// FIM_BAIXO   | closing low, 50 us
// HOLDOFF     | bus ignored after a frame
module dht11_sensor_emulator
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int MIN_START_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int HOLDOFF_US    = 2000
) (
    input  logic                    clock,
    input  logic                    reset,
    inout  wire                     dht11,
    dht11_sensor_emulator_if.slave  ctl
);

    localparam logic [3:0] IDLE        = E_IDLE;
    localparam logic [3:0] MEDE_INICIO = E_MEDE_INICIO;
    localparam logic [3:0] ATRASO      = E_ATRASO;
    localparam logic [3:0] RESP_BAIXO  = E_RESP_BAIXO;
    localparam logic [3:0] RESP_ALTO   = E_RESP_ALTO;
    localparam logic [3:0] BIT_BAIXO   = E_BIT_BAIXO;
    localparam logic [3:0] BIT_ALTO    = E_BIT_ALTO;
    localparam logic [3:0] FIM_BAIXO   = E_FIM_BAIXO;
    localparam logic [3:0] HOLDOFF     = E_HOLDOFF;

    localparam logic [15:0] MIN_START = 16'(MIN_START_US);
    localparam logic [15:0] D_ATRASO  = 16'(RESP_DELAY_US);
    localparam logic [15:0] D_HOLD    = 16'(HOLDOFF_US);
    localparam logic [15:0] D_RESP    = 16'(T_RESP_US);
    localparam logic [15:0] D_BIT_LO  = 16'(T_BIT_LOW_US);
    localparam logic [15:0] D_BIT0_HI = 16'(T_BIT0_HIGH_US);
    localparam logic [15:0] D_BIT1_HI = 16'(T_BIT1_HIGH_US);
    localparam logic [15:0] D_FIM_LO  = 16'(T_END_LOW_US);

    logic        tick;
    logic [1:0]  sync_q;
    logic        bus_s;
    logic [3:0]  estado_q, estado_d;
    logic [15:0] timer_q, timer_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic [39:0] frame_q, frame_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] dur_fase;
    logic        fim_fase;
    logic        puxa_baixo;

    gerador_tick_us #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .tick_o (tick)
    );

    assign bus_s = sync_q[1];

    always_comb begin
        case (estado_q)
            ATRASO:     dur_fase = D_ATRASO;
            RESP_BAIXO: dur_fase = D_RESP;
            RESP_ALTO:  dur_fase = D_RESP;
            BIT_BAIXO:  dur_fase = D_BIT_LO;
            BIT_ALTO:   dur_fase = frame_q[39] ? D_BIT1_HI : D_BIT0_HI;
            FIM_BAIXO:  dur_fase = D_FIM_LO;
            HOLDOFF:    dur_fase = D_HOLD;
            default:    dur_fase = 16'hFFFF;
        endcase
    end

    // Phase ends on the Nth tick after entry (timer already holds N-1).
    assign fim_fase = tick && (({1'b0, timer_q} + 17'd1) >= {1'b0, dur_fase});

    always_comb begin
        estado_d     = estado_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        if (tick && timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end

        case (estado_q)
            IDLE: begin
                if (!bus_s && ctl.resposta_habilitada) begin
                    estado_d = MEDE_INICIO;
                    timer_d  = '0;
                end
            end
            MEDE_INICIO: begin
                if (bus_s) begin
                    timer_d = '0;
                    if (timer_q >= MIN_START) begin
                        frame_d  = {ctl.umidade_int, ctl.umidade_dec,
                                    ctl.temperatura_int, ctl.temperatura_dec,
                                    calc_checksum(ctl.umidade_int, ctl.umidade_dec,
                                                  ctl.temperatura_int, ctl.temperatura_dec,
                                                  ctl.injeta_erro_checksum)};
                        estado_d = ATRASO;
                    end else begin
                        estado_d = IDLE;
                    end
                end
            end
            ATRASO: begin
                if (fim_fase) begin
                    estado_d = RESP_BAIXO;
                    timer_d  = '0;
                end
            end
            RESP_BAIXO: begin
                if (fim_fase) begin
                    estado_d = RESP_ALTO;
                    timer_d  = '0;
                end
            end
            RESP_ALTO: begin
                if (fim_fase) begin
                    estado_d  = BIT_BAIXO;
                    timer_d   = '0;
                    bit_idx_d = '0;
                end
            end
            BIT_BAIXO: begin
                if (fim_fase) begin
                    estado_d = BIT_ALTO;
                    timer_d  = '0;
                end
            end
            BIT_ALTO: begin
                if (fim_fase) begin
                    timer_d = '0;
                    frame_d = {frame_q[38:0], 1'b0};
                    if (bit_idx_q < 6'd39) begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        estado_d  = BIT_BAIXO;
                    end else begin
                        estado_d  = FIM_BAIXO;
                    end
                end
            end
            FIM_BAIXO: begin
                if (fim_fase) begin
                    estado_d     = HOLDOFF;
                    timer_d      = '0;
                    bit_idx_d    = '0;
                    frame_done_d = 1'b1;
                end
            end
            HOLDOFF: begin
                if (fim_fase) begin
                    estado_d = IDLE;
                    timer_d  = '0;
                end
            end
            default: begin
                estado_d = IDLE;
                timer_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q       <= 2'b11;
            estado_q     <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], dht11};
            estado_q     <= estado_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Drive decoded straight from the state register so reset frees the bus at once.
    assign puxa_baixo = (estado_q == RESP_BAIXO) || (estado_q == BIT_BAIXO) ||
                        (estado_q == FIM_BAIXO);
    assign dht11      = puxa_baixo ? 1'b0 : 1'bz;

    assign ctl.busy       = (estado_q == ATRASO)    || (estado_q == RESP_BAIXO) ||
                            (estado_q == RESP_ALTO) || (estado_q == BIT_BAIXO)  ||
                            (estado_q == BIT_ALTO)  || (estado_q == FIM_BAIXO)  ||
                            (estado_q == HOLDOFF);
    assign ctl.frame_done = frame_done_q;

endmodule
